// File: rtl/jtkcpu_mshift_if.sv
// Bus bundle for the jtkcpu_mshift multi-cycle shifter: request side, result side
// and an FSM state tap.
interface jtkcpu_mshift_if #(
  parameter int W  = 16,
  parameter int CW = 5
);
  // Handshake: start is sampled only on a cen-high rising edge while the FSM is
  // in IDLE or DONE; busy is high in SHIFT; done is high for exactly one cen
  // cycle (it holds across cen-low cycles) and marks dout and flags as valid.
  logic          cen;
  logic          start;
  logic [2:0]    mode;
  logic [W-1:0]  din;
  logic [CW-1:0] cnt;
  logic          cin;
  logic [W-1:0]  dout;
  logic          busy;
  logic          done;
  logic          c_out;
  logic          v_out;
  logic          z_out;
  logic          n_out;
  logic [1:0]    state;

  modport master (
    output cen, start, mode, din, cnt, cin,
    input  dout, busy, done, c_out, v_out, z_out, n_out, state
  );

  modport slave (
    input  cen, start, mode, din, cnt, cin,
    output dout, busy, done, c_out, v_out, z_out, n_out, state
  );
endinterface

// File: rtl/jtkcpu_mshift.sv
// Iterative shifter/rotator (LSR, ASR, ASL, ROR, ROL) with C/V/Z/N flags.
// Define JTKCPU_MSHIFT_FAST_EN to perform two steps per cen cycle.
module jtkcpu_mshift #(
  parameter int W  = 16,
  parameter int CW = 5
) (
  input logic              rst,
  input logic              clk,
  jtkcpu_mshift_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    mode_q, mode_d;
  logic [W-1:0]  d_q, d_d;
  logic          c_q, c_d, v_q, v_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          c_out_q, c_out_d, v_out_q, v_out_d;
  logic [W+1:0]  s1, sn;
  logic [CW-1:0] dec;
`ifdef JTKCPU_MSHIFT_FAST_EN
  logic [W+1:0]  s2;
`endif

  // One 1-bit step; result packed as {data, carry, overflow}
  function automatic logic [W+1:0] step_fn(input logic [2:0] m, input logic [W-1:0] d,
                                           input logic c, input logic v);
    logic [W-1:0] nd;
    logic         nc;
    logic         nv;
    nd = d;
    nc = c;
    nv = v;
    case (m)
      3'd0: begin nd = {1'b0, d[W-1:1]};   nc = d[0]; end
      3'd1: begin nd = {d[W-1], d[W-1:1]}; nc = d[0]; end
      3'd2: begin nd = {d[W-2:0], 1'b0};   nc = d[W-1]; nv = v | (d[W-1] ^ d[W-2]); end
      3'd3: begin nd = {c, d[W-1:1]};      nc = d[0]; end
      3'd4: begin nd = {d[W-2:0], c};      nc = d[W-1]; nv = v | (d[W-1] ^ d[W-2]); end
      default: ;
    endcase
    return {nd, nc, nv};
  endfunction

  always_comb begin
    s1 = step_fn(mode_q, d_q, c_q, v_q);
`ifdef JTKCPU_MSHIFT_FAST_EN
    s2 = step_fn(mode_q, s1[W+1:2], s1[1], s1[0]);
    if (cnt_q > CW'(1)) begin
      sn  = s2;
      dec = CW'(2);
    end else begin
      sn  = s1;
      dec = CW'(1);
    end
`else
    sn  = s1;
    dec = CW'(1);
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    d_d     = d_q;
    c_d     = c_q;
    v_d     = v_q;
    dout_d  = dout_q;
    c_out_d = c_out_q;
    v_out_d = v_out_q;
    case (state_q)
      SHIFT: begin
        {d_d, c_d, v_d} = sn;
        cnt_d = cnt_q - dec;
        if (cnt_q == dec) begin
          state_d = DONE;
          dout_d  = sn[W+1:2];
          c_out_d = sn[1];
          v_out_d = sn[0];
        end
      end
      default: begin
        if (bus.start) begin
          mode_d = bus.mode;
          d_d    = bus.din;
          cnt_d  = bus.cnt;
          c_d    = bus.cin;
          v_d    = 1'b0;
          // Reserved modes and zero counts finish immediately with the operand
          if (bus.cnt != '0 && bus.mode <= 3'd4) begin
            state_d = SHIFT;
          end else begin
            state_d = DONE;
            cnt_d   = '0;
            dout_d  = bus.din;
            c_out_d = bus.cin;
            v_out_d = 1'b0;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      d_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      dout_q  <= '0;
      c_out_q <= 1'b0;
      v_out_q <= 1'b0;
    end else if (bus.cen) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      d_q     <= d_d;
      c_q     <= c_d;
      v_q     <= v_d;
      dout_q  <= dout_d;
      c_out_q <= c_out_d;
      v_out_q <= v_out_d;
    end
  end

  assign bus.dout  = dout_q;
  assign bus.busy  = (state_q == SHIFT);
  assign bus.done  = (state_q == DONE);
  assign bus.c_out = c_out_q;
  assign bus.v_out = v_out_q;
  assign bus.z_out = (dout_q == '0);
  assign bus.n_out = dout_q[W-1];
  assign bus.state = state_q;

endmodule

// File: tb/tb_jtkcpu_mshift.sv
// Bench for jtkcpu_mshift: directed corner cases plus random operations scored
// against an arithmetic shift/rotate model.
module tb_jtkcpu_mshift;
  localparam int W  = 16;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst;

  jtkcpu_mshift_if #(.W(W), .CW(CW)) bus ();
  jtkcpu_mshift #(.W(W), .CW(CW)) dut (.rst(rst), .clk(clk), .bus(bus));

  // clock / reset
  always #5 clk = ~clk;

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  slow  = 1'b0;
  int  ph    = 0;
  logic [W+1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Advance to the next falling edge and choose cen for the coming rising edge
  task automatic tick();
    @(negedge clk);
    if (slow) begin
      bus.cen = (ph == 0);
      ph = (ph + 1) % 3;
    end else begin
      bus.cen = 1'b1;
    end
  endtask

  // Reference result {dout, C, V} from whole-operation arithmetic
  function automatic logic [W+1:0] model(input int m, input logic [W-1:0] d, input int k,
                                         input logic ci);
    longint unsigned val, mask, win, ring, rmask;
    longint          sv;
    logic [W-1:0]    r;
    logic            c, v, b0;
    int              s, idx;
    r = d;
    c = ci;
    v = 1'b0;
    if (k == 0 || m > 4) return {d, ci, 1'b0};
    rmask = (64'd1 << (W + 1)) - 1;
    ring  = longint'({ci, d});
    case (m)
      0: begin
        val = longint'(d) >> k;
        r = W'(val);
        if (k <= W) c = d[k-1]; else c = 1'b0;
      end
      1: begin
        sv = longint'(signed'(d));
        sv = sv >>> k;
        r = W'(sv);
        if (k <= W) c = d[k-1]; else c = d[W-1];
      end
      2: begin
        val  = longint'(d) << k;
        r    = W'(val);
        c    = val[W];
        mask = (64'd1 << (k + 1)) - 1;
        win  = (val >> (W - 1)) & mask;
        v    = (win != 0) && (win != mask);
      end
      3: begin
        s = k % (W + 1);
        ring = ((ring >> s) | (ring << (W + 1 - s))) & rmask;
        r = W'(ring);
        c = ring[W];
      end
      default: begin
        b0 = ring[W-1];
        for (int j = 1; j <= k; j++) begin
          idx = (((W - 1 - j) % (W + 1)) + (W + 1)) % (W + 1);
          if (ring[idx] != b0) v = 1'b1;
        end
        s = k % (W + 1);
        ring = ((ring << s) | (ring >> (W + 1 - s))) & rmask;
        r = W'(ring);
        c = ring[W];
      end
    endcase
    return {r, c, v};
  endfunction

  // driver: issue one operation, measure busy, score the result
  task automatic do_op(input int m, input logic [W-1:0] d, input int k, input logic ci,
                       input bit b2b, input bit poke);
    logic [W+1:0] e;
    int busy_n, guard, exp_busy;
    bit poked;
    exp_q.push_back(model(m, d, k, ci));
`ifdef JTKCPU_MSHIFT_FAST_EN
    exp_busy = (k + 1) / 2;
`else
    exp_busy = k;
`endif
    if (k == 0 || m > 4) exp_busy = 0;
    bus.start = 1'b1;
    bus.mode  = 3'(m);
    bus.din   = d;
    bus.cnt   = CW'(k);
    bus.cin   = ci;
    while (!bus.cen) tick();
    tick();
    bus.start = 1'b0;
    bus.din   = W'($urandom);
    bus.cnt   = CW'($urandom);
    bus.cin   = 1'($urandom);
    bus.mode  = 3'($urandom_range(0, 4));
    busy_n = 0;
    guard  = 0;
    poked  = 1'b0;
    while (!bus.done && guard < 300) begin
      if (bus.busy && bus.cen) busy_n++;
      if (poke && bus.busy && !poked) begin
        bus.start = 1'b1;
        poked = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      guard++;
    end
    bus.start = 1'b0;
    chk("done_timeout", 32'(guard < 300), 32'd1);
    chk("busy_cycles", 32'(busy_n), 32'(exp_busy));
    e = exp_q.pop_front();
    chk("dout", 32'(bus.dout), 32'(e[W+1:2]));
    chk("c_out", 32'(bus.c_out), 32'(e[1]));
    chk("v_out", 32'(bus.v_out), 32'(e[0]));
    chk("z_out", 32'(bus.z_out), 32'(e[W+1:2] == '0));
    chk("n_out", 32'(bus.n_out), 32'(e[W+1]));
    if (!b2b) begin
      while (!bus.cen) begin
        chk("done_hold", 32'(bus.done), 32'd1);
        tick();
      end
      tick();
      chk("done_pulse", 32'(bus.done), 32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_dout_hold", 32'(bus.dout), 32'(e[W+1:2]));
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.cen   = 1'b0;
    bus.start = 1'b0;
    bus.mode  = '0;
    bus.din   = '0;
    bus.cnt   = '0;
    bus.cin   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_cvnz", 32'({bus.c_out, bus.v_out, bus.n_out, bus.z_out}), 32'b0001);
    rst = 1'b0;
    tick();

    do_op(0, 16'h8001, 1, 1'b0, 1'b0, 1'b0);
    do_op(2, 16'h4000, 3, 1'b0, 1'b0, 1'b0);
    do_op(3, 16'h0001, 17, 1'b0, 1'b0, 1'b0);
    do_op(1, 16'h8000, 20, 1'b0, 1'b0, 1'b1);
    do_op(0, 16'hFFFF, 18, 1'b1, 1'b0, 1'b0);
    do_op(4, 16'h8000, 1, 1'b0, 1'b0, 1'b0);
    do_op(4, 16'h5A5A, 4, 1'b1, 1'b1, 1'b0);
    do_op(3, 16'h1234, 5, 1'b1, 1'b0, 1'b0);
    slow = 1'b1;
    do_op(2, 16'h00F0, 0, 1'b1, 1'b0, 1'b0);
    do_op(6, 16'hBEEF, 5, 1'b0, 1'b0, 1'b0);
    do_op(2, 16'h3001, 7, 1'b0, 1'b0, 1'b0);
    slow = 1'b0;
    tick();

    // reset on the second SHIFT cycle of ROL by 4 aborts without done
    bus.start = 1'b1;
    bus.mode  = 3'd4;
    bus.din   = 16'hC3A5;
    bus.cnt   = CW'(4);
    bus.cin   = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_dout", 32'(bus.dout), 32'd0);
    chk("abort_busy_clr", 32'(bus.busy), 32'd0);
    chk("abort_cvnz", 32'({bus.c_out, bus.v_out, bus.n_out, bus.z_out}), 32'b0001);
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_done", 32'(bus.done), 32'd0);
      tick();
    end

    for (int i = 0; i < 40; i++) begin
      slow = ($urandom_range(0, 3) == 0);
      do_op(int'($urandom_range(0, 7)), W'($urandom), int'($urandom_range(0, 31)),
            1'($urandom), (i != 39) && ($urandom_range(0, 2) == 0), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/jtkcpu_mshift.md
JTKCPU_MSHIFT -- requirements
Module: jtkcpu_mshift

Interface
REQ-001 SHALL have parameter W, default 16, data width in bits (legal 8..32).
REQ-002 SHALL have parameter CW, default 5, shift-count width in bits (max count 2^CW-1).
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port cen  input  1  clock enable; state advances only when high.
REQ-006 SHALL have port start  input  1  request; sampled only on cen cycles.
REQ-007 SHALL have port mode  input  3  0 LSR, 1 ASR, 2 ASL, 3 ROR, 4 ROL, 5-7 reserved.
REQ-008 SHALL have port din  input  W  operand.
REQ-009 SHALL have port cnt  input  CW  number of 1-bit steps.
REQ-010 SHALL have port cin  input  1  carry in (rotate source, C result when cnt=0).
REQ-011 SHALL have port dout  output  W  result register.
REQ-012 SHALL have port busy  output  1  high while shifting.
REQ-013 SHALL have port done  output  1  one-cen-cycle pulse; dout and flags valid.
REQ-014 SHALL have ports c_out, v_out, z_out, n_out  output  1 each  C, V, Z, N result flags.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE; busy=1 only in SHIFT, done=1 only in DONE.
REQ-016 SHALL accept start only in IDLE or DONE; start in SHIFT is ignored.
REQ-017 On accept, SHALL latch mode and din into the working register, load the step counter with cnt, set C=cin, V=0, and go to SHIFT if cnt!=0, else DONE.
REQ-018 Each cen cycle in SHIFT SHALL perform one step and decrement the counter; the step that brings it to 0 SHALL move to DONE.
REQ-019 Latency: for count k>0, busy SHALL be high for exactly k cen cycles after accept and done SHALL pulse on the next one; for k=0, done SHALL pulse on the first cen cycle after accept.
REQ-020 LSR step SHALL be {0, d[W-1:1]} with C=d[0]; ASR step SHALL be {d[W-1], d[W-1:1]} with C=d[0].
REQ-021 ASL step SHALL be {d[W-2:0], 0} with C=d[W-1]; ROL step SHALL be {d[W-2:0], C} with C=d[W-1].
REQ-022 ROR step SHALL be {C, d[W-1:1]} with C=d[0]; rotates SHALL pass through C (W+1-bit ring).
REQ-023 V SHALL be the OR over all ASL/ROL steps of (msb before step XOR msb after step); V SHALL be 0 for LSR, ASR, ROR.
REQ-024 Z SHALL equal (dout==0) and N SHALL equal dout[W-1], both updated with dout.
REQ-025 Counts >= W SHALL be legal and execute fully (e.g. LSR by W+2 gives 0, C=0).
REQ-026 Reserved modes SHALL behave as cnt=0: dout=din, C=cin, V=0.
REQ-027 DONE SHALL return to IDLE on the next cen cycle unless start is high, in which case the new request is accepted back-to-back.
REQ-028 dout and flags SHALL hold their values in IDLE until the next accept.
REQ-029 With cen low, no state, counter, output or flag SHALL change; done SHALL stay high until the next cen cycle.

Reset
REQ-030 rst high on a clk edge SHALL force IDLE, dout=0, busy=0, done=0, c_out=v_out=n_out=0, z_out=1, counter=0, regardless of cen.
REQ-031 rst during SHIFT SHALL abort the operation with no done pulse.

Configuration
REQ-032 Macro JTKCPU_MSHIFT_FAST_EN: when defined, SHIFT SHALL perform two steps per cen cycle (one if a single step remains), busy lasting ceil(k/2) cen cycles; results and flags SHALL be identical to the one-step build.
REQ-033 Without JTKCPU_MSHIFT_FAST_EN, exactly one step per cen cycle SHALL be performed.

Verification
REQ-034 W=16, LSR, din=8001h, cnt=1, cin=0 -> busy 1 cycle, then done; dout=4000h, C=1, V=0, Z=0, N=0.
REQ-035 W=16, ASL, din=4000h, cnt=3 -> busy 3 cycles; dout=0000h, C=0, V=1, Z=1, N=0.
REQ-036 W=8, ROR, din=01h, cnt=9, cin=0 -> busy 9 cycles; dout=01h, C=0 (full 9-bit ring).
REQ-037 W=16, ASR, din=8000h, cnt=20 -> dout=FFFFh, C=1, N=1; start pulsed mid-SHIFT is ignored.
REQ-038 cnt=0 with cin=1, and mode 6 with cnt=5 -> done on the first cen cycle, dout=din, C=cin, V=0; cen toggled 1-of-3 stretches timing only.
REQ-039 rst asserted on the 2nd SHIFT cycle of ROL cnt=4 -> no done, all outputs at reset values the next cycle; repeat with JTKCPU_MSHIFT_FAST_EN -> busy 2 cycles, identical results.
